uart_response_framer: RTL

UART_RESPONSE_FRAMER -- requirements
Module: uart_response_framer

---
 rtl/uart_response_framer_if.sv | 40 ++++
 rtl/uart_response_framer.sv | 124 ++++++++++++
 2 files changed

// File: rtl/uart_response_framer_if.sv
// Bundle of the framer's signals: payload write port, response request and the
// byte stream toward the UART transmitter.
interface uart_response_framer_if #(
  parameter int PAYLOAD_DEPTH = 16
);
  localparam int ADDR_W = $clog2(PAYLOAD_DEPTH);

  logic              pl_wr_en;
  logic [ADDR_W-1:0] pl_wr_addr;
  logic [7:0]        pl_wr_data;

  logic              resp_start;
  logic [7:0]        resp_cmd;
  logic [7:0]        resp_status;
  logic [8:0]        resp_len;

  logic [7:0]        tx_byte;
  logic              tx_byte_valid;
  logic              tx_ready;

  logic              busy;
  logic              resp_done;
  logic              resp_error;

  // framer side
  modport slave (
    input  pl_wr_en, pl_wr_addr, pl_wr_data,
    input  resp_start, resp_cmd, resp_status, resp_len,
    input  tx_ready,
    output tx_byte, tx_byte_valid, busy, resp_done, resp_error
  );

  // requester / transmitter side
  modport master (
    output pl_wr_en, pl_wr_addr, pl_wr_data,
    output resp_start, resp_cmd, resp_status, resp_len,
    output tx_ready,
    input  tx_byte, tx_byte_valid, busy, resp_done, resp_error
  );
endinterface

// File: rtl/uart_response_framer.sv
// Response framer: serialises SYNC, cmd, status, len, payload and an 8-bit
// additive checksum into a valid/ready byte stream for a UART transmitter.
//
// state     | meaning
// ----------+-----------------------------------------------
// S_IDLE    | no frame; payload buffer writable, requests accepted
// S_SYNC    | offering SYNC_BYTE
// S_CMD     | offering the latched command byte
// S_STATUS  | offering the latched status byte
// S_LEN     | offering len[7:0]; skips to S_CSUM when len is zero
// S_PAYLOAD | offering payload[cnt], cnt runs 0..len-1
// S_CSUM    | offering the checksum; frame ends on its handshake
module uart_response_framer #(
  parameter int         PAYLOAD_DEPTH = 16,
  parameter logic [7:0] SYNC_BYTE     = 8'hA5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  uart_response_framer_if.slave bus
);
  localparam int         ADDR_W  = $clog2(PAYLOAD_DEPTH);
  localparam logic [8:0] MAX_LEN = 9'(PAYLOAD_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_CMD, S_STATUS, S_LEN, S_PAYLOAD, S_CSUM
  } state_t;

  state_t     state, state_nx;
  logic [7:0] mem [PAYLOAD_DEPTH];
  logic [7:0] cmd_q, status_q, csum_q;
  logic [8:0] len_q, cnt_q;
  logic [7:0] tx_byte_w;
  logic       valid_w;
  logic       busy_w;
  logic       hs;
  logic       start_ok;
  logic       start_bad;

  assign busy_w    = (state != S_IDLE);
  assign hs        = valid_w && bus.tx_ready;
  assign start_ok  = bus.resp_start && !busy_w && (bus.resp_len <= MAX_LEN);
  assign start_bad = bus.resp_start && !start_ok;

  assign bus.tx_byte       = tx_byte_w;
  assign bus.tx_byte_valid = valid_w;
  assign bus.busy          = busy_w;

  // state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // next-state: every step past IDLE waits for a handshake
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (start_ok) state_nx = S_SYNC;
      S_SYNC:    if (hs) state_nx = S_CMD;
      S_CMD:     if (hs) state_nx = S_STATUS;
      S_STATUS:  if (hs) state_nx = S_LEN;
      S_LEN:     if (hs) state_nx = (len_q == 9'd0) ? S_CSUM : S_PAYLOAD;
      S_PAYLOAD: if (hs && (cnt_q == len_q - 9'd1)) state_nx = S_CSUM;
      S_CSUM:    if (hs) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // outputs: the offered byte is a pure function of state and latched data,
  // so it cannot change while the transmitter stalls
  always_comb begin
    tx_byte_w = 8'h00;
    valid_w   = 1'b1;
    case (state)
      S_SYNC:    tx_byte_w = SYNC_BYTE;
      S_CMD:     tx_byte_w = cmd_q;
      S_STATUS:  tx_byte_w = status_q;
      S_LEN:     tx_byte_w = len_q[7:0];
      S_PAYLOAD: tx_byte_w = mem[cnt_q[ADDR_W-1:0]];
      S_CSUM:    tx_byte_w = csum_q;
      default: begin
        tx_byte_w = 8'h00;
        valid_w   = 1'b0;
      end
    endcase
  end

  // request latch, payload counter, running checksum and status pulses
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q          <= 8'h00;
      status_q       <= 8'h00;
      len_q          <= 9'd0;
      cnt_q          <= 9'd0;
      csum_q         <= 8'h00;
      bus.resp_done  <= 1'b0;
      bus.resp_error <= 1'b0;
    end else begin
      bus.resp_done  <= hs && (state == S_CSUM);
      bus.resp_error <= start_bad;
      if (start_ok) begin
        cmd_q    <= bus.resp_cmd;
        status_q <= bus.resp_status;
        len_q    <= bus.resp_len;
        cnt_q    <= 9'd0;
        csum_q   <= 8'h00;
      end else if (hs) begin
        case (state)
          S_CMD, S_STATUS, S_LEN: csum_q <= csum_q + tx_byte_w;
          S_PAYLOAD: begin
            csum_q <= csum_q + tx_byte_w;
            cnt_q  <= cnt_q + 9'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // payload buffer: writable only between frames, contents not reset
  always_ff @(posedge clock) begin
    if (bus.pl_wr_en && !busy_w) mem[bus.pl_wr_addr] <= bus.pl_wr_data;
  end
endmodule
